// File: rtl/lcd_nios2_oci_dct_packer.sv
// Debug-compressed-trace packer: gathers SLICE_W-bit trace slices into DEPTH-slice
// frames, hands them out on a valid/ready port, and flushes a partial frame at end of test.
module lcd_nios2_oci_dct_packer #(
    parameter int unsigned SLICE_W = 3,
    parameter int unsigned DEPTH   = 10,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned FCNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [SLICE_W-1:0]         in_slice,
    output logic                       in_ready,
    input  logic                       test_ending,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*DEPTH-1:0]   dct_buffer,
    output logic [CNT_W-1:0]           dct_count,
    output logic                       test_has_ended,
    output logic [FCNT_W-1:0]          frames_sent
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_HOLD  = 2'd1,
        S_ENDED = 2'd2
    } state_t;

    state_t           state;
    logic             ending_q;
    logic             accept;
    logic             ending_now;
    logic             fill_done;
    logic [CNT_W-1:0] count_next;

    // Ready depends only on registered state, never on in_valid.
    assign in_ready   = (state == S_FILL) && !ending_q;
    assign accept     = in_valid && in_ready;
    assign ending_now = test_ending || ending_q;
    assign fill_done  = accept && (dct_count == CNT_W'(DEPTH - 1));
    assign count_next = accept ? dct_count + CNT_W'(1) : dct_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_FILL;
            ending_q       <= 1'b0;
            out_valid      <= 1'b0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            test_has_ended <= 1'b0;
            frames_sent    <= '0;
        end else begin
            if (test_ending && (state != S_ENDED)) begin
                ending_q <= 1'b1;
            end

            case (state)
                S_FILL: begin
                    if (accept) begin
                        for (int k = 0; k < int'(DEPTH); k++) begin
                            if (dct_count == CNT_W'(k)) begin
                                dct_buffer[k*SLICE_W +: SLICE_W] <= in_slice;
                            end
                        end
                        dct_count <= count_next;
                    end
                    // A slice accepted alongside test_ending joins the flushed frame.
                    if (fill_done) begin
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                    end else if (ending_now) begin
                        if (count_next != '0) begin
                            state     <= S_HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            state          <= S_ENDED;
                            test_has_ended <= 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        dct_buffer  <= '0;
                        dct_count   <= '0;
                        frames_sent <= frames_sent + FCNT_W'(1);
                        if (ending_now) begin
                            state          <= S_ENDED;
                            test_has_ended <= 1'b1;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end

                S_ENDED: begin
                    state <= S_ENDED;
                end

                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_nios2_oci_dct_packer.sv
// Directed bench for the DCT packer: default 3x10 instance plus a 4x4 instance.
module tb_lcd_nios2_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, test_ending, out_ready;
    logic [2:0]  in_slice;
    logic        in_ready, out_valid, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [15:0] frames_sent;

    logic        in_valid6, test_ending6, out_ready6;
    logic [3:0]  in_slice6;
    logic        in_ready6, out_valid6, test_has_ended6;
    logic [15:0] dct_buffer6;
    logic [2:0]  dct_count6;
    logic [15:0] frames_sent6;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lcd_nios2_oci_dct_packer u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_slice(in_slice),
        .in_ready(in_ready), .test_ending(test_ending), .out_valid(out_valid),
        .out_ready(out_ready), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_has_ended(test_has_ended), .frames_sent(frames_sent)
    );

    lcd_nios2_oci_dct_packer #(.SLICE_W(4), .DEPTH(4), .CNT_W(3), .FCNT_W(16)) u_dut6 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid6), .in_slice(in_slice6),
        .in_ready(in_ready6), .test_ending(test_ending6), .out_valid(out_valid6),
        .out_ready(out_ready6), .dct_buffer(dct_buffer6), .dct_count(dct_count6),
        .test_has_ended(test_has_ended6), .frames_sent(frames_sent6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 0; in_slice = '0; test_ending = 0; out_ready = 0;
        in_valid6 = 0; in_slice6 = '0; test_ending6 = 0; out_ready6 = 0;
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_slice = '0; test_ending = 0; out_ready = 0;
        in_valid6 = 0; in_slice6 = '0; test_ending6 = 0; out_ready6 = 0;
        reset_n = 0;
        tick();
        n_checks++; if ({out_valid, dct_buffer, dct_count, test_has_ended, frames_sent} !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got v=%b buf=%o cnt=%0d end=%b fs=%0d, want all 0",
                                 out_valid, dct_buffer, dct_count, test_has_ended, frames_sent); end
        reset_n = 1;
        n_checks++; if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full_frame();
        logic [2:0] vals [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        apply_reset();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_slice = vals[i];
            tick();
        end
        in_valid = 0;
        n_checks++; if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL full_valid: got %b want 1", out_valid); end
        n_checks++; if (dct_count !== 4'd10) begin
            n_errors++; $display("FAIL full_count: got %0d want 10", dct_count); end
        n_checks++; if (dct_buffer !== 30'o2107654321) begin
            n_errors++; $display("FAIL full_buffer: got %o want 2107654321", dct_buffer); end
        n_checks++; if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL full_in_ready_hold: got %b want 0", in_ready); end
        tick();
        n_checks++; if ({out_valid, dct_count, dct_buffer} !== '0) begin
            n_errors++; $display("FAIL full_after_hs: got v=%b cnt=%0d buf=%o want 0", out_valid, dct_count, dct_buffer); end
        n_checks++; if (frames_sent !== 16'd1) begin
            n_errors++; $display("FAIL full_frames_sent: got %0d want 1", frames_sent); end
        n_checks++; if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL full_in_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int vcount = 0;
        apply_reset();
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 22; i++) begin
            in_slice = 3'(i);
            tick();
            if (out_valid === 1'b1) vcount++;
        end
        in_valid = 0;
        n_checks++; if (vcount !== 2) begin
            n_errors++; $display("FAIL b2b_valid_cycles: got %0d want 2", vcount); end
        n_checks++; if (frames_sent !== 16'd2) begin
            n_errors++; $display("FAIL b2b_frames: got %0d want 2", frames_sent); end
    endtask

    task automatic test_partial_flush();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_slice = 3'(5 + i);
            tick();
        end
        in_valid = 0; test_ending = 1;
        tick();
        test_ending = 0;
        n_checks++; if (out_valid !== 1'b1 || dct_count !== 4'd3) begin
            n_errors++; $display("FAIL flush_hold: got v=%b cnt=%0d want v=1 cnt=3", out_valid, dct_count); end
        n_checks++; if (dct_buffer !== 30'o765) begin
            n_errors++; $display("FAIL flush_buffer: got %o want 765", dct_buffer); end
        out_ready = 1;
        tick();
        n_checks++; if (test_has_ended !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_ended: got end=%b v=%b want end=1 v=0", test_has_ended, out_valid); end
        n_checks++; if (frames_sent !== 16'd1) begin
            n_errors++; $display("FAIL flush_frames: got %0d want 1", frames_sent); end
        in_valid = 1; test_ending = 1;
        tick();
        tick();
        in_valid = 0; test_ending = 0;
        n_checks++; if (in_ready !== 1'b0 || test_has_ended !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_terminal: got rdy=%b end=%b v=%b want 0,1,0", in_ready, test_has_ended, out_valid); end
    endtask

    task automatic test_stall();
        logic [29:0] exp_buf = '0;
        int bad = 0;
        apply_reset();
        out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_slice = 3'(i % 8);
            exp_buf[i*3 +: 3] = 3'(i % 8);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = 1; in_slice = 3'($urandom);
            tick();
            if (out_valid !== 1'b1 || dct_buffer !== exp_buf || dct_count !== 4'd10 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_cycle%0d: got v=%b buf=%o cnt=%0d rdy=%b want 1,%o,10,0",
                         i, out_valid, dct_buffer, dct_count, in_ready, exp_buf);
            end
        end
        n_checks++; if (bad != 0) n_errors++;
        in_valid = 0; out_ready = 1;
        tick();
        n_checks++; if (frames_sent !== 16'd1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL stall_release: got fs=%0d v=%b want 1,0", frames_sent, out_valid); end
    endtask

    task automatic test_empty_end();
        int seen = 0;
        apply_reset();
        out_ready = 1;
        test_ending = 1;
        tick();
        test_ending = 0;
        n_checks++; if (test_has_ended !== 1'b1) begin
            n_errors++; $display("FAIL empty_ended: got %b want 1", test_has_ended); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0 || frames_sent !== 16'd0) begin
            n_errors++; $display("FAIL empty_no_frame: got valids=%0d fs=%0d want 0,0", seen, frames_sent); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_slice = 3'(i + 1);
            tick();
        end
        in_valid = 0;
        #2 reset_n = 0;
        #1;
        n_checks++; if ({out_valid, dct_buffer, dct_count, test_has_ended, frames_sent} !== '0) begin
            n_errors++; $display("FAIL arst_midframe: got v=%b buf=%o cnt=%0d want 0", out_valid, dct_buffer, dct_count); end
        tick();
        reset_n = 1;
        n_checks++; if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL arst_ready: got %b want 1", in_ready); end
        in_valid = 1; in_slice = 3'd3;
        tick();
        in_valid = 0;
        n_checks++; if (dct_buffer !== 30'o3 || dct_count !== 4'd1) begin
            n_errors++; $display("FAIL arst_slot0: got buf=%o cnt=%0d want 3,1", dct_buffer, dct_count); end
        out_ready = 0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1; in_slice = 3'd7;
            tick();
        end
        in_valid = 0;
        n_checks++; if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL arst_pre_hold: got %b want 1", out_valid); end
        #2 reset_n = 0;
        #1;
        n_checks++; if ({out_valid, dct_buffer, dct_count, frames_sent} !== '0) begin
            n_errors++; $display("FAIL arst_hold: got v=%b buf=%o cnt=%0d fs=%0d want 0", out_valid, dct_buffer, dct_count, frames_sent); end
        tick();
        reset_n = 1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL arst_hold_release: got v=%b rdy=%b want 0,1", out_valid, in_ready); end
    endtask

    task automatic test_param_4x4();
        logic [3:0] first [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        apply_reset();
        out_ready6 = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid6 = 1; in_slice6 = first[i];
            tick();
        end
        in_valid6 = 0;
        n_checks++; if (out_valid6 !== 1'b1 || dct_buffer6 !== 16'hDCBA || dct_count6 !== 3'd4) begin
            n_errors++; $display("FAIL p4_frame: got v=%b buf=%h cnt=%0d want 1,DCBA,4", out_valid6, dct_buffer6, dct_count6); end
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid6 = 1; in_slice6 = 4'(i + 1);
            tick();
        end
        in_valid6 = 0;
        tick();
        in_valid6 = 1; in_slice6 = 4'h5;
        tick();
        n_checks++; if (dct_count6 !== 3'd1 || frames_sent6 !== 16'd2) begin
            n_errors++; $display("FAIL p4_ninth: got cnt=%0d fs=%0d want 1,2", dct_count6, frames_sent6); end
        in_slice6 = 4'h6; test_ending6 = 1;
        tick();
        in_valid6 = 0; test_ending6 = 0;
        n_checks++; if (out_valid6 !== 1'b1 || dct_count6 !== 3'd2 || dct_buffer6 !== 16'h0065) begin
            n_errors++; $display("FAIL p4_partial: got v=%b cnt=%0d buf=%h want 1,2,0065", out_valid6, dct_count6, dct_buffer6); end
        tick();
        n_checks++; if (test_has_ended6 !== 1'b1 || frames_sent6 !== 16'd3) begin
            n_errors++; $display("FAIL p4_end: got end=%b fs=%0d want 1,3", test_has_ended6, frames_sent6); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_partial_flush();
        test_stall();
        test_empty_end();
        test_async_reset();
        test_param_4x4();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
